// File: rtl/block_rasterizer.sv
// block_rasterizer: buffers one 8x8 IDCT block per colour channel and streams
// the assembled pixels out in raster order (row-major) with valid/ready flow
// control. Optional macro DOUBLE_BUF_EN adds a second bank per channel so the
// next block set can be written while the current one streams out; without it
// a single bank is used and writes are refused for the whole stream.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for every channel of the read bank to be filled
// STREAM | presenting pixel idx of the read bank, advancing on handshake
module block_rasterizer #(
  parameter int CH    = 3,
  parameter int PIX_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [$clog2(CH+1)-1:0]       ch_in,
  input  logic [7:0][7:0][PIX_W-1:0]    blk_in,
  output logic [CH-1:0]                 ch_full,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [CH-1:0][PIX_W-1:0]      pix_out,
  output logic [2:0]                    row_out,
  output logic [2:0]                    col_out,
  output logic                          last_out,
  output logic                          err
);

  localparam int CHW = $clog2(CH+1);
`ifdef DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [7:0][7:0][PIX_W-1:0] mem_q [NBANK][CH];
  logic [CH-1:0]              full_q [NBANK];
  logic [CH-1:0]              full_d [NBANK];
  logic [0:0]                 state_q, state_d;
  logic [5:0]                 idx_q, idx_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic                       err_q, err_d;

  logic [CH-1:0] ch_sel;
  logic          wr_en;
  logic          handshake;
  logic          final_hs;

  // One-hot decode of the channel index; an out-of-range index selects nothing.
  always_comb begin
    ch_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (ch_in == CHW'(c)) ch_sel[c] = 1'b1;
    end
  end

  // Write acceptance is judged against the registered (pre-clear) full flags,
  // so a write colliding with the final handshake of the same bank is refused.
  assign wr_en     = valid_in && (|ch_sel) && !(|(ch_sel & full_q[wr_bank_q]));
  assign handshake = (state_q == STREAM) && ready_out;
  assign final_hs  = handshake && (idx_q == 6'd63);

  // Next-state for full flags, bank pointers, error flag, FSM and pixel index.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q | (valid_in && !wr_en);

    if (wr_en) full_d[wr_bank_q] = full_q[wr_bank_q] | ch_sel;
    if (final_hs) full_d[rd_bank_q] = '0;

`ifdef DOUBLE_BUF_EN
    // Once the write bank is complete, point writes at the other bank.
    if (wr_en && (&full_d[wr_bank_q])) wr_bank_d = ~wr_bank_q;
    if (final_hs) rd_bank_d = ~rd_bank_q;
`endif

    case (state_q)
      IDLE: begin
        // Using the next-state flags gives one cycle from last write to (0,0).
        if (&full_d[rd_bank_q]) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      default: begin
        if (handshake) idx_d = idx_q + 6'd1;
        if (final_hs) begin
          idx_d = '0;
          if (!(&full_d[rd_bank_d])) state_d = IDLE;
        end
      end
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      full_q    <= '{default: '0};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      err_q     <= err_d;
    end
  end

  // Block storage is not reset; its contents only matter behind a full flag.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (wr_en && ch_sel[c]) mem_q[wr_bank_q][c] <= blk_in;
    end
  end

  // Read mux: one sample per channel at the current raster position.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      pix_out[c] = mem_q[rd_bank_q][c][idx_q[5:3]][idx_q[2:0]];
    end
  end

  assign valid_out = (state_q == STREAM);
  assign last_out  = valid_out && (idx_q == 6'd63);
  assign row_out   = idx_q[5:3];
  assign col_out   = idx_q[2:0];
  assign ch_full   = full_q[wr_bank_q];
  assign err       = err_q;

endmodule

// File: tb/tb_block_rasterizer.sv
// Directed bench for block_rasterizer: a table of write vectors followed by
// hand-written streaming sequences (back-pressure, mid-stream reset, collision
// with the final handshake and, when DOUBLE_BUF_EN is set, ping-pong overlap).
module tb_block_rasterizer;

  localparam int CH    = 3;
  localparam int PIX_W = 8;
  localparam int CHW   = $clog2(CH+1);
`ifdef DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef logic [7:0][7:0][PIX_W-1:0] blk_t;

  typedef struct {
    bit            vld;
    int            ch;
    int            base;
    logic [CH-1:0] exp_full;
    bit            exp_valid;
    bit            exp_err;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     valid_in;
  logic [CHW-1:0]           ch_in;
  blk_t                     blk_in;
  logic [CH-1:0]            ch_full;
  logic                     valid_out;
  logic                     ready_out;
  logic [CH-1:0][PIX_W-1:0] pix_out;
  logic [2:0]               row_out;
  logic [2:0]               col_out;
  logic                     last_out;
  logic                     err;

  int n_vec = 0;
  int n_err = 0;
  bit exp_err = 1'b0;

  block_rasterizer #(.CH(CH), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ch_in     (ch_in),
    .blk_in    (blk_in),
    .ch_full   (ch_full),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .pix_out   (pix_out),
    .row_out   (row_out),
    .col_out   (col_out),
    .last_out  (last_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic blk_t mk_blk(input int ch, input int base);
    blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = PIX_W'(base + r*8 + c + ch*64);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input int b, input int base);
    logic [CH-1:0][PIX_W-1:0] exp_pix;
    for (int c = 0; c < CH; c++) exp_pix[c] = PIX_W'(base + b + c*64);
    chk($sformatf("valid b%0d", b), 32'(valid_out), 32'd1);
    chk($sformatf("pos b%0d", b), 32'({row_out, col_out}), 32'(b));
    chk($sformatf("last b%0d", b), 32'(last_out), 32'(b == 63));
    chk($sformatf("pix b%0d", b), 32'(pix_out), 32'(exp_pix));
  endtask

  task automatic wr_blk(input int ch, input int base);
    valid_in = 1'b1;
    ch_in    = CHW'(ch);
    blk_in   = mk_blk(ch, base);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Streams one full block from beat 0, optionally stalling each beat for a
  // cycle and optionally colliding a write with the final handshake.
  task automatic run_stream(input bit toggle, input int base, input bit wr_last);
    logic [CH-1:0] exp_full_in;
    logic [CH-1:0] exp_full_after;
    exp_full_in    = DB ? '0 : '1;
    exp_full_after = (wr_last && DB) ? CH'(3'b010) : '0;
    chk("full_in_stream", 32'(ch_full), 32'(exp_full_in));
    for (int b = 0; b < 64; b++) begin
      if (toggle) begin
        ready_out = 1'b0;
        @(posedge clk); #1;
        check_beat(b, base);
      end
      check_beat(b, base);
      ready_out = 1'b1;
      if (b == 63 && wr_last) begin
        valid_in = 1'b1;
        ch_in    = CHW'(1);
        blk_in   = mk_blk(1, 50);
      end
      @(posedge clk); #1;
      valid_in  = 1'b0;
      ready_out = 1'b0;
    end
    if (wr_last && !DB) exp_err = 1'b1;
    chk("post_valid", 32'(valid_out), 32'd0);
    chk("post_last", 32'(last_out), 32'd0);
    chk("post_full", 32'(ch_full), 32'(exp_full_after));
    chk("post_err", 32'(err), 32'(exp_err));
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 0, 0,   3'b000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 0, 0,   3'b001, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 0, 100, 3'b001, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3, 0,   3'b001, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 0, 0,   3'b001, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 2, 0,   3'b101, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1, 0,   3'b111, 1'b1, 1'b1};

    rst       = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    ch_in     = '0;
    blk_in    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_full", 32'(ch_full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_last", 32'(last_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Writes in any order, a duplicate channel and an out-of-range channel.
    for (int i = 0; i < 7; i++) begin
      logic [CH-1:0] ef;
      ef       = (DB && tbl[i].exp_valid) ? '0 : tbl[i].exp_full;
      valid_in = tbl[i].vld;
      ch_in    = CHW'(tbl[i].ch);
      blk_in   = mk_blk(tbl[i].ch, tbl[i].base);
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk($sformatf("tbl%0d_full", i), 32'(ch_full), 32'(ef));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
    end
    exp_err = 1'b1;

    // Continuous ready: 64 back-to-back beats, first ch-0 data retained.
    run_stream(1'b0, 0, 1'b0);

    // Ready toggling 1,0,1,0: every beat held through a stall cycle.
    wr_blk(2, 5); wr_blk(0, 5); wr_blk(1, 5);
    run_stream(1'b1, 5, 1'b0);

`ifdef DOUBLE_BUF_EN
    // Set B written into the other bank while set A streams; no gap between.
    wr_blk(0, 20); wr_blk(1, 20); wr_blk(2, 20);
    for (int b = 0; b < 64; b++) begin
      check_beat(b, 20);
      ready_out = 1'b1;
      if (b < 3) begin
        valid_in = 1'b1;
        ch_in    = CHW'(b);
        blk_in   = mk_blk(b, 30);
      end
      @(posedge clk); #1;
      valid_in  = 1'b0;
      ready_out = 1'b0;
    end
    run_stream(1'b0, 30, 1'b0);
`endif

    // Reset in the middle of a stream at beat 20.
    wr_blk(1, 7); wr_blk(0, 7); wr_blk(2, 7);
    for (int b = 0; b < 20; b++) begin
      ready_out = 1'b1;
      @(posedge clk); #1;
    end
    check_beat(20, 7);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_full", 32'(ch_full), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_last", 32'(last_out), 32'd0);
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("after_rst_valid%0d", k), 32'(valid_out), 32'd0);
    end
    ready_out = 1'b0;

    // Fresh set streams from idx 0; a write collides with the final handshake.
    wr_blk(0, 9); wr_blk(2, 9); wr_blk(1, 9);
    run_stream(1'b0, 9, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/block_rasterizer.md
BLOCK_RASTERIZER -- requirements
Module: block_rasterizer

Interface
REQ-001 SHALL have parameter CH, default 3, meaning the number of colour channels buffered per block position.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the bit width of one unsigned pixel sample.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1 bit: blk_in and ch_in are valid this cycle.
REQ-006 SHALL have port ch_in, input, $clog2(CH+1) bits: channel index of blk_in.
REQ-007 SHALL have port blk_in, input, [7:0][7:0] x PIX_W bits: the 8x8 IDCT output block, indexed [row][col].
REQ-008 SHALL have port ch_full, output, CH bits: bit c is high while channel c cannot accept a block.
REQ-009 SHALL have port valid_out, output, 1 bit: pix_out is valid.
REQ-010 SHALL have port ready_out, input, 1 bit: the downstream stage accepts pix_out.
REQ-011 SHALL have port pix_out, output, [CH-1:0] x PIX_W bits: one pixel with all channels, channel 0 in element 0.
REQ-012 SHALL have port row_out and port col_out, output, 3 bits each: raster position of pix_out within the block.
REQ-013 SHALL have port last_out, output, 1 bit: pix_out is pixel (7,7) of the block.
REQ-014 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL hold one 64-sample block buffer per channel (per bank), each with a full flag; ch_full equals the registered full flags of the write bank.
REQ-016 SHALL accept a block when valid_in=1, ch_in<CH and full[ch_in]=0: capture blk_in in 1 cycle and set full[ch_in].
REQ-017 SHALL drop a block arriving with valid_in=1 and full[ch_in]=1, or with ch_in>=CH, without changing any buffer, and SHALL set err.
REQ-018 SHALL use an FSM with states IDLE and STREAM; IDLE->STREAM on the cycle after all CH full flags of the read bank are set.
REQ-019 SHALL, in STREAM, assert valid_out and present the buffered pixel at a 6-bit counter idx (row=idx[5:3], col=idx[2:0]), with idx starting at 0.
REQ-020 SHALL increment idx only on the cycle where valid_out=1 and ready_out=1; pix_out, row_out and col_out SHALL remain stable while ready_out=0.
REQ-021 SHALL assert last_out exactly when idx=63 and valid_out=1.
REQ-022 SHALL, on the handshake at idx=63, clear all read-bank full flags, wrap idx to 0, and return to IDLE (or stay in STREAM if the other bank is complete, under DOUBLE_BUF_EN).
REQ-023 SHALL have a latency of exactly 1 cycle from accepting the last missing channel to valid_out=1 with pixel (0,0).
REQ-024 SHALL evaluate a write in the same cycle as a final (idx=63) handshake against the pre-clear full flags; without DOUBLE_BUF_EN that write is dropped and err is set.
REQ-025 SHALL accept channel blocks in any order and interleaving.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, idx=0, all full flags=0, bank pointers=0, valid_out=0, last_out=0, err=0, and ch_full=0.
REQ-027 SHALL, on an assertion of rst in the middle of a stream, discard the partial block; no further pixels of that block SHALL be output after rst is released.
REQ-028 SHALL not reset the buffer contents, so pix_out is a don't-care while valid_out=0.

Configuration
REQ-029 SHALL support the macro DOUBLE_BUF_EN. When defined: two banks per channel in ping-pong operation; writes go to the write bank while the read bank streams; banks swap on the final handshake; ch_full reflects the write bank. When undefined: a single bank; all channels are full throughout STREAM, so the block cannot overlap writes with streaming.

Verification
REQ-030 SHALL cover this scenario: write Y, Cb, Cr blocks with pixel=(r*8+c)+ch*64, and hold ready_out=1 -> 64 beats in consecutive cycles with pix_out[ch]=idx+ch*64, and last_out high only on beat 63.
REQ-031 SHALL cover this scenario: toggle ready_out 1,0,1,0 during the stream -> no pixel is skipped or duplicated, and outputs stay stable while ready_out=0.
REQ-032 SHALL cover this scenario: write ch 0 twice before ch 1 -> the second block is dropped, err=1, and the stream outputs the first ch-0 data.
REQ-033 SHALL cover this scenario: write with ch_in=3 (CH=3) -> no buffer change, err=1, and ch_full is unchanged.
REQ-034 SHALL cover this scenario: with DOUBLE_BUF_EN, write block set B while set A streams -> B's pixel (0,0) is output in the cycle after A's beat 63, with no gap.
REQ-035 SHALL cover this scenario: assert rst at beat 20 and release it -> valid_out=0, ch_full=0, and err=0; a new complete block set streams from idx 0.
